// File: rtl/wb_queue_if.sv
// Bus bundle for wb_queue: four result lanes in, one register-file write port out.
// Lookup signals exist only when WB_BYPASS_EN is defined.
interface wb_queue_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic        inValid0, inValid1, inValid2, inValid3;
  logic [4:0]  inReg0, inReg1, inReg2, inReg3;
  logic [31:0] inData0, inData1, inData2, inData3;
  logic        inReady;
  logic        wrEnable;
  logic [4:0]  wrReg;
  logic [31:0] wrData;
  logic [CW-1:0] count;
`ifdef WB_BYPASS_EN
  logic [4:0]  lookupReg0, lookupReg1, lookupReg2, lookupReg3;
  logic        lookupHit0, lookupHit1, lookupHit2, lookupHit3;
  logic [31:0] lookupData0, lookupData1, lookupData2, lookupData3;
`endif

  modport slave (
    input  inValid0, inValid1, inValid2, inValid3,
    input  inReg0, inReg1, inReg2, inReg3,
    input  inData0, inData1, inData2, inData3,
    output inReady, wrEnable, wrReg, wrData, count
`ifdef WB_BYPASS_EN
    ,
    input  lookupReg0, lookupReg1, lookupReg2, lookupReg3,
    output lookupHit0, lookupHit1, lookupHit2, lookupHit3,
    output lookupData0, lookupData1, lookupData2, lookupData3
`endif
  );

  modport master (
    output inValid0, inValid1, inValid2, inValid3,
    output inReg0, inReg1, inReg2, inReg3,
    output inData0, inData1, inData2, inData3,
    input  inReady, wrEnable, wrReg, wrData, count
`ifdef WB_BYPASS_EN
    ,
    output lookupReg0, lookupReg1, lookupReg2, lookupReg3,
    input  lookupHit0, lookupHit1, lookupHit2, lookupHit3,
    input  lookupData0, lookupData1, lookupData2, lookupData3
`endif
  );
endinterface

// File: rtl/wb_queue.sv
// Writeback queue: packs up to four results per cycle, drains one register write per cycle.
// Define WB_BYPASS_EN to add the four combinational pending-write lookup ports.
module wb_queue #(
  parameter int DEPTH = 8
) (
  input logic       clk,
  input logic       rstN,
  wb_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    regMem  [DEPTH];
  logic [31:0]   dataMem [DEPTH];
  logic [AW-1:0] head, tail;
  logic [CW-1:0] cnt;

  logic [3:0]    laneValid;
  logic [4:0]    laneReg  [4];
  logic [31:0]   laneData [4];
  logic [3:0]    laneTake;
  logic [AW-1:0] laneSlot [4];
  logic [2:0]    accCount;
  logic          pop;

  assign laneValid   = {bus.inValid3, bus.inValid2, bus.inValid1, bus.inValid0};
  assign laneReg[0]  = bus.inReg0;
  assign laneReg[1]  = bus.inReg1;
  assign laneReg[2]  = bus.inReg2;
  assign laneReg[3]  = bus.inReg3;
  assign laneData[0] = bus.inData0;
  assign laneData[1] = bus.inData1;
  assign laneData[2] = bus.inData2;
  assign laneData[3] = bus.inData3;

  // Readiness uses only the registered count so it never depends on this cycle's pop.
  assign bus.inReady = (CW'(DEPTH) - cnt) >= CW'(4);
  assign pop         = (cnt != '0);

  // Each accepted lane lands at tail plus the number of accepted lanes before it.
  always_comb begin
    accCount = '0;
    for (int k = 0; k < 4; k++) begin
      laneTake[k] = bus.inReady && laneValid[k] && (laneReg[k] != 5'd0);
      laneSlot[k] = tail + AW'(accCount);
      accCount    = accCount + 3'(laneTake[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (pop) head <= head + AW'(1);
      tail <= tail + AW'(accCount);
      cnt  <= cnt + CW'(accCount) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (laneTake[k]) begin
        regMem[laneSlot[k]]  <= laneReg[k];
        dataMem[laneSlot[k]] <= laneData[k];
      end
    end
  end

  assign bus.wrEnable = pop;
  assign bus.wrReg    = pop ? regMem[head]  : 5'd0;
  assign bus.wrData   = pop ? dataMem[head] : 32'd0;
  assign bus.count    = cnt;

`ifdef WB_BYPASS_EN
  logic [4:0]    lkReg  [4];
  logic [3:0]    lkHit;
  logic [31:0]   lkData [4];
  logic [AW-1:0] idx;

  assign lkReg[0] = bus.lookupReg0;
  assign lkReg[1] = bus.lookupReg1;
  assign lkReg[2] = bus.lookupReg2;
  assign lkReg[3] = bus.lookupReg3;

  // Scan oldest to newest so the last matching entry supplies the data.
  always_comb begin
    idx = '0;
    for (int k = 0; k < 4; k++) begin
      lkHit[k]  = 1'b0;
      lkData[k] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        idx = head + AW'(i);
        if ((CW'(i) < cnt) && (lkReg[k] != 5'd0) && (regMem[idx] == lkReg[k])) begin
          lkHit[k]  = 1'b1;
          lkData[k] = dataMem[idx];
        end
      end
    end
  end

  assign bus.lookupHit0  = lkHit[0];
  assign bus.lookupHit1  = lkHit[1];
  assign bus.lookupHit2  = lkHit[2];
  assign bus.lookupHit3  = lkHit[3];
  assign bus.lookupData0 = lkData[0];
  assign bus.lookupData1 = lkData[1];
  assign bus.lookupData2 = lkData[2];
  assign bus.lookupData3 = lkData[3];
`endif
endmodule

// File: tb/tb_wb_queue.sv
// Testbench for wb_queue: a count model plus an expected-write queue checked on every drain.
module tb_wb_queue;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;
  int   mCount      = 0;
  int   pendingAcc  = 0;
  bit   monOn       = 1'b0;
  logic [36:0] sb[$];

  wb_queue_if #(.DEPTH(DEPTH)) bus();
  wb_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rstN(rstN), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference count and scoreboard flush follow the same edge the DUT uses.
  always @(posedge clk) begin
    if (!rstN) begin
      mCount <= 0;
      sb.delete();
    end else begin
      mCount <= mCount + pendingAcc - ((mCount != 0) ? 1 : 0);
    end
  end

  // Every write the DUT issues must be the oldest expected entry.
  always @(negedge clk) begin
    if (monOn) begin
      vectors++;
      if (bus.count !== CW'(mCount)) begin
        miscompares++;
        $display("[TB] FAIL count: got %0d, expected %0d", bus.count, mCount);
      end
      vectors++;
      if (bus.inReady !== ((DEPTH - mCount) >= 4)) begin
        miscompares++;
        $display("[TB] FAIL inReady: got %0b, expected %0b", bus.inReady, ((DEPTH - mCount) >= 4));
      end
      vectors++;
      if (bus.wrEnable !== (mCount != 0)) begin
        miscompares++;
        $display("[TB] FAIL wrEnable: got %0b, expected %0b", bus.wrEnable, (mCount != 0));
      end
      if (bus.wrEnable === 1'b1) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL write_unexpected: got reg %0d data %0h, expected no write", bus.wrReg, bus.wrData);
        end else begin
          logic [36:0] exp;
          exp = sb.pop_front();
          if ({bus.wrReg, bus.wrData} !== exp) begin
            miscompares++;
            $display("[TB] FAIL write_order: got reg %0d data %0h, expected reg %0d data %0h",
                     bus.wrReg, bus.wrData, exp[36:32], exp[31:0]);
          end
        end
      end else begin
        vectors++;
        if (bus.wrReg !== 5'd0 || bus.wrData !== 32'd0) begin
          miscompares++;
          $display("[TB] FAIL idle_zero: got reg %0d data %0h, expected 0 0", bus.wrReg, bus.wrData);
        end
      end
    end
  end

  task automatic drive(input logic rstVal, input logic [3:0] v, input logic [19:0] r, input logic [127:0] d);
    int acc;
    logic [4:0] rk;
    logic [31:0] dk;
    @(posedge clk);
    #2;
    rstN = rstVal;
    bus.inValid0 = v[0];  bus.inValid1 = v[1];  bus.inValid2 = v[2];  bus.inValid3 = v[3];
    bus.inReg0 = r[4:0];  bus.inReg1 = r[9:5];  bus.inReg2 = r[14:10]; bus.inReg3 = r[19:15];
    bus.inData0 = d[31:0];  bus.inData1 = d[63:32];
    bus.inData2 = d[95:64]; bus.inData3 = d[127:96];
    acc = 0;
    if (rstVal && ((DEPTH - mCount) >= 4)) begin
      for (int k = 0; k < 4; k++) begin
        rk = r[k*5 +: 5];
        dk = d[k*32 +: 32];
        if (v[k] && rk != 5'd0) begin
          sb.push_back({rk, dk});
          acc++;
        end
      end
    end
    pendingAcc = acc;
  endtask

  task automatic idle();
    drive(1'b1, 4'h0, 20'd0, 128'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH * 4 && mCount != 0; i++) idle();
    vectors++;
    if (mCount != 0) begin
      miscompares++;
      $display("[TB] FAIL drain_timeout: got %0d entries left, expected 0", mCount);
    end
  endtask

  task automatic test_reset();
    drive(1'b0, 4'hF, {5'd4, 5'd3, 5'd2, 5'd1}, {32'hDD, 32'hCC, 32'hBB, 32'hAA});
    idle();
    @(negedge clk);
    vectors++;
    if ({bus.wrEnable, bus.wrReg, bus.wrData, bus.inReady, bus.count} !== {1'b0, 5'd0, 32'd0, 1'b1, CW'(0)}) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got en %0b reg %0d data %0h rdy %0b cnt %0d, expected 0 0 0 1 0",
               bus.wrEnable, bus.wrReg, bus.wrData, bus.inReady, bus.count);
    end
  endtask

  task automatic test_basic();
    drive(1'b1, 4'hF, {5'd4, 5'd3, 5'd2, 5'd1}, {32'hD0D0_0004, 32'hC0C0_0003, 32'hB0B0_0002, 32'hA0A0_0001});
    idle();
    @(negedge clk);
    vectors++;
    if ({bus.wrEnable, bus.wrReg, bus.wrData} !== {1'b1, 5'd1, 32'hA0A0_0001}) begin
      miscompares++;
      $display("[TB] FAIL basic_latency: got en %0b reg %0d data %0h, expected 1 1 a0a00001",
               bus.wrEnable, bus.wrReg, bus.wrData);
    end
    repeat (4) begin
      idle();
      @(negedge clk);
    end
    vectors++;
    if (bus.count !== CW'(0)) begin
      miscompares++;
      $display("[TB] FAIL basic_empty: got count %0d, expected 0", bus.count);
    end
  endtask

  task automatic test_discard();
    drive(1'b1, 4'hF, {5'd6, 5'd0, 5'd5, 5'd0}, {32'h6666, 32'h0BAD, 32'h5555, 32'h0BAD});
    idle();
    @(negedge clk);
    vectors++;
    if (bus.count !== CW'(2)) begin
      miscompares++;
      $display("[TB] FAIL discard_count: got %0d, expected 2", bus.count);
    end
    drain();
  endtask

  task automatic test_backpressure();
    for (int b = 0; b < 3; b++)
      drive(1'b1, 4'hF, {5'd14, 5'd13, 5'd12, 5'd11} + 20'(b), {4{32'h1000 + 32'(b)}});
    @(negedge clk);
    vectors++;
    if (bus.count !== CW'(7) || bus.inReady !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL full_burst: got count %0d rdy %0b, expected 7 0", bus.count, bus.inReady);
    end
    drive(1'b1, 4'hF, {5'd24, 5'd23, 5'd22, 5'd21}, {4{32'h2000}});
    drive(1'b1, 4'hF, {5'd28, 5'd27, 5'd26, 5'd25}, {4{32'h3000}});
    idle();
    @(negedge clk);
    vectors++;
    if (bus.count !== CW'(4) || bus.inReady !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ready_return: got count %0d rdy %0b, expected 4 1", bus.count, bus.inReady);
    end
    drain();
  endtask

  task automatic test_wrap();
    logic [19:0] r;
    logic [127:0] d;
    for (int b = 0; b < 10; b++) begin
      for (int k = 0; k < 4; k++) begin
        r[k*5 +: 5]  = 5'($urandom_range(0, 31));
        d[k*32 +: 32] = $urandom;
      end
      drive(1'b1, 4'hF, r, d);
      idle();
    end
    drain();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 4'hF, {5'd4, 5'd3, 5'd2, 5'd1}, {32'h44, 32'h33, 32'h22, 32'h11});
    drive(1'b1, 4'h3, {5'd0, 5'd0, 5'd9, 5'd8}, {32'h0, 32'h0, 32'h99, 32'h88});
    drive(1'b0, 4'hF, {5'd17, 5'd18, 5'd19, 5'd20}, {4{32'hDEAD}});
    @(negedge clk);
    vectors++;
    if (bus.count !== CW'(5)) begin
      miscompares++;
      $display("[TB] FAIL pre_reset_count: got %0d, expected 5", bus.count);
    end
    for (int i = 0; i < 4; i++) begin
      idle();
      @(negedge clk);
      vectors++;
      if (bus.wrEnable !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_drop: got wrEnable %0b in cycle %0d, expected 0", bus.wrEnable, i);
      end
    end
  endtask

`ifdef WB_BYPASS_EN
  task automatic test_bypass();
    bus.lookupReg0 = 5'd7;
    bus.lookupReg1 = 5'd0;
    bus.lookupReg2 = 5'd7;
    bus.lookupReg3 = 5'd3;
    drive(1'b1, 4'h3, {5'd0, 5'd0, 5'd7, 5'd7}, {32'h0, 32'h0, 32'h22, 32'h11});
    @(negedge clk);
    vectors++;
    if (bus.lookupHit2 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL bypass_same_cycle: got hit %0b, expected 0", bus.lookupHit2);
    end
    idle();
    @(negedge clk);
    vectors++;
    if (bus.lookupHit0 !== 1'b1 || bus.lookupData0 !== 32'h22) begin
      miscompares++;
      $display("[TB] FAIL bypass_newest: got hit %0b data %0h, expected 1 22", bus.lookupHit0, bus.lookupData0);
    end
    vectors++;
    if (bus.lookupHit1 !== 1'b0 || bus.lookupData1 !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL bypass_reg0: got hit %0b data %0h, expected 0 0", bus.lookupHit1, bus.lookupData1);
    end
    vectors++;
    if (bus.lookupHit3 !== 1'b0 || bus.lookupData3 !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL bypass_miss: got hit %0b data %0h, expected 0 0", bus.lookupHit3, bus.lookupData3);
    end
    drain();
  endtask
`endif

  initial begin
    bus.inValid0 = 1'b0; bus.inValid1 = 1'b0; bus.inValid2 = 1'b0; bus.inValid3 = 1'b0;
    bus.inReg0 = 5'd0;   bus.inReg1 = 5'd0;   bus.inReg2 = 5'd0;   bus.inReg3 = 5'd0;
    bus.inData0 = 32'd0; bus.inData1 = 32'd0; bus.inData2 = 32'd0; bus.inData3 = 32'd0;
`ifdef WB_BYPASS_EN
    bus.lookupReg0 = 5'd0; bus.lookupReg1 = 5'd0; bus.lookupReg2 = 5'd0; bus.lookupReg3 = 5'd0;
`endif
    drive(1'b0, 4'h0, 20'd0, 128'd0);
    monOn = 1'b1;
    $display("[TB] starting wb_queue checks");
    test_reset();
    test_basic();
    test_discard();
    test_backpressure();
    test_wrap();
    test_reset_mid();
`ifdef WB_BYPASS_EN
    test_bypass();
`endif
    drain();
    idle();
    @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL leftover: got %0d expected writes pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 Parameter DEPTH, default 8: queue entries; a power of two, at least 4.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rstN  in  1  synchronous, active-low reset.
REQ-004 inValid0..inValid3  in  1 each  result-lane valid from the execution units.
REQ-005 inReg0..inReg3  in  5 each  destination register index per lane.
REQ-006 inData0..inData3  in  32 each  result data per lane.
REQ-007 inReady  out  1  queue can accept all four lanes this cycle.
REQ-008 wrEnable  out  1  write strobe; drives register-file writeEnable0.
REQ-009 wrReg  out  5  write index; drives register-file write0.
REQ-010 wrData  out  32  write data; drives register-file dataIn0.
REQ-011 count  out  $clog2(DEPTH)+1  number of occupied entries.
REQ-012 lookupReg0..lookupReg3  in  5 each  bypass query index; present only with WB_BYPASS_EN.
REQ-013 lookupHit0..lookupHit3  out  1 each  pending write exists for the queried register; present only with WB_BYPASS_EN.
REQ-014 lookupData0..lookupData3  out  32 each  data of the newest pending write; present only with WB_BYPASS_EN.

Function
REQ-015 inReady SHALL be 1 when DEPTH-count >= 4, using the registered count; it SHALL NOT depend on the same-cycle pop.
REQ-016 A lane SHALL be accepted in a cycle when inReady=1, its inValid=1 and its inReg!=0.
REQ-017 Lanes with inReg=0 SHALL be discarded and SHALL NOT occupy an entry.
REQ-018 Accepted lanes SHALL be written into consecutive entries at the tail, in lane order 0,1,2,3, with no gaps.
REQ-019 When inReady=0, all lanes SHALL be ignored, with no partial acceptance.
REQ-020 Head entry output: wrEnable=(count!=0), and wrReg/wrData SHALL equal the head entry combinationally.
REQ-021 When count=0, wrReg and wrData SHALL be 0.
REQ-022 The head SHALL pop every cycle in which wrEnable=1, giving one write per cycle with no backpressure.
REQ-023 Latency: a result accepted in cycle N with an empty queue SHALL appear on wrEnable in cycle N+1.
REQ-024 Simultaneous push and pop SHALL be legal; the next count SHALL equal count + accepted - popped.
REQ-025 Head and tail pointers SHALL wrap modulo DEPTH.
REQ-026 The queue SHALL never overflow; by construction count <= DEPTH.
REQ-027 Multiple entries for the same register SHALL drain in program (acceptance) order, so the last write wins in the register file.

Reset
REQ-028 While rstN=0 at a clock edge, the head pointer, tail pointer and count SHALL clear to 0.
REQ-029 The resulting outputs SHALL be wrEnable=0, wrReg=0, wrData=0 and inReady=1.
REQ-030 Inputs presented in a reset cycle SHALL be discarded.
REQ-031 A reset mid-drain SHALL drop all pending entries with no further writes.
REQ-032 Entry storage SHALL need no reset.

Configuration
REQ-033 Macro WB_BYPASS_EN, when defined, SHALL compile in the four lookup ports.
REQ-034 With WB_BYPASS_EN, lookupHitK SHALL be 1 when any occupied entry, including the head, has reg=lookupRegK.
REQ-035 With WB_BYPASS_EN, lookupDataK SHALL be the data of the newest such entry, or 0 on a miss.
REQ-036 With WB_BYPASS_EN, the lookup SHALL be combinational, and lookupRegK=0 SHALL always miss.
REQ-037 With WB_BYPASS_EN, lanes being accepted in the same cycle SHALL NOT be visible to the lookup.
REQ-038 Without WB_BYPASS_EN, the lookup ports and the search logic SHALL be absent, with all other behaviour identical.

Verification
REQ-039 Reset, then all lanes valid with regs 1,2,3,4 and data A,B,C,D -> wrEnable=1 for 4 consecutive cycles with (1,A),(2,B),(3,C),(4,D), then count=0.
REQ-040 Lanes with regs 0,5,0,6 -> only 5 and 6 are enqueued, and count=2 the next cycle.
REQ-041 DEPTH=8, two full 4-lane bursts on back-to-back cycles -> count reaches 7; no third burst is accepted while inReady=0 (DEPTH-count<4); inReady returns to 1 once count<=4.
REQ-042 Wrap-around: 10 alternating bursts -> the write sequence on wrReg/wrData exactly matches acceptance order.
REQ-043 rstN=0 with count=5 -> wrEnable=0 on the next cycle, and no further writes occur.
REQ-044 With WB_BYPASS_EN, entries (7,0x11) then (7,0x22) queued -> lookupReg0=7 gives hit=1 and data=0x22; lookupReg1=0 gives hit=0 and data=0.
